uart_cmd_parser: RTL and testbench

- Sits directly downstream of the UART receiver, on the same receive clock.
- Drains received bytes through the receiver's unload handshake (rx_empty / uld_rx_data / rx_data).
- Frames each command as: sync byte, command byte, length byte, payload bytes, XOR checksum.
- Streams the payload into the consumer's staging buffer, then signals either a validated command or a classified error to the logic-analyzer control logic.

---
 rtl/uart_cmd_parser_pkg.sv | 27 ++
 rtl/uart_cmd_parser_if.sv | 29 ++
 rtl/uart_rx_fetch.sv | 41 ++++
 rtl/uart_cmd_parser.sv | 159 +++++++++++++++
 tb/tb_uart_cmd_parser.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_parser_pkg.sv
// Shared constants and state encodings for the UART command parser.
package uart_cmd_parser_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_CSUM = 2'd1,
    ERR_LEN  = 2'd2,
    ERR_TO   = 2'd3
  } err_e;

  typedef enum logic [2:0] {
    P_SYNC = 3'd0,
    P_CMD  = 3'd1,
    P_LEN  = 3'd2,
    P_PAY  = 3'd3,
    P_CSUM = 3'd4
  } pstate_e;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_ULD  = 2'd1,
    F_CAP  = 2'd2
  } fstate_e;

endpackage

// File: rtl/uart_cmd_parser_if.sv
// UART unload handshake plus payload/command outputs of the command parser.
interface uart_cmd_parser_if #(
  parameter int unsigned AW = 4
);
  logic [7:0]    rx_data;
  logic          rx_empty;
  logic          uld_rx_data;
  logic          pl_we;
  logic [AW-1:0] pl_addr;
  logic [7:0]    pl_data;
  logic          cmd_valid;
  logic [7:0]    cmd_code;
  logic [7:0]    cmd_len;
  logic          cmd_err;
  logic [1:0]    err_code;
  logic          busy;

  modport master (
    input  rx_data, rx_empty,
    output uld_rx_data, pl_we, pl_addr, pl_data, cmd_valid, cmd_code,
           cmd_len, cmd_err, err_code, busy
  );

  modport slave (
    output rx_data, rx_empty,
    input  uld_rx_data, pl_we, pl_addr, pl_data, cmd_valid, cmd_code,
           cmd_len, cmd_err, err_code, busy
  );
endinterface

// File: rtl/uart_rx_fetch.sv
// Drains the UART receiver one byte per three cycles via its unload handshake.
module uart_rx_fetch
  import uart_cmd_parser_pkg::*;
(
  input  logic       rxclk,
  input  logic       reset_n,
  input  logic       rx_empty,
  input  logic [7:0] rx_data,
  output logic       uld_rx_data,
  output logic       byte_stb,
  output logic [7:0] rx_byte_c
);

  fstate_e state_q, state_d;

  // rx_data is valid in F_CAP, the cycle after the unload pulse
  assign rx_byte_c = rx_data;

  always_comb begin
    state_d = state_q;
    case (state_q)
      F_IDLE:  if (!rx_empty) state_d = F_ULD;
      F_ULD:   state_d = F_CAP;
      F_CAP:   state_d = F_IDLE;
      default: state_d = F_IDLE;
    endcase
  end

  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= F_IDLE;
      uld_rx_data <= 1'b0;
      byte_stb    <= 1'b0;
    end else begin
      state_q     <= state_d;
      uld_rx_data <= (state_d == F_ULD);
      byte_stb    <= (state_d == F_CAP);
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Frames UART bytes into sync/cmd/len/payload/checksum commands, streams the
// payload out and reports an accepted command or a classified rejection.
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter logic [7:0]      SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int unsigned     MAX_LEN   = 16,
  parameter int unsigned     AW        = 4,
  parameter int unsigned     TO_W      = 20,
  parameter logic [TO_W-1:0] TIMEOUT   = 20'hFFFFF
) (
  input  logic               rxclk,
  input  logic               reset_n,
  uart_cmd_parser_if.master  bus
);

  logic       byte_stb;
  logic [7:0] rx_byte_c;

  uart_rx_fetch u_fetch (
    .rxclk       (rxclk),
    .reset_n     (reset_n),
    .rx_empty    (bus.rx_empty),
    .rx_data     (bus.rx_data),
    .uld_rx_data (bus.uld_rx_data),
    .byte_stb    (byte_stb),
    .rx_byte_c   (rx_byte_c)
  );

  pstate_e         pstate_q, pstate_d;
  logic [7:0]      csum_q, csum_d, code_q, code_d, len_q, len_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            pl_we_q, pl_we_d, valid_q, valid_d, err_q, err_d, busy_q;
  logic [AW-1:0]   pl_addr_q, pl_addr_d;
  logic [7:0]      pl_data_q, pl_data_d, cmd_code_q, cmd_code_d, cmd_len_q, cmd_len_d;
  err_e            err_code_q, err_code_d;
  logic            timeout_hit_c;

  assign timeout_hit_c = (pstate_q != P_SYNC) && (to_cnt_q == TIMEOUT - TO_W'(1));

  always_comb begin
    pstate_d   = pstate_q;
    csum_d     = csum_q;
    code_d     = code_q;
    len_d      = len_q;
    idx_d      = idx_q;
    to_cnt_d   = (byte_stb || pstate_q == P_SYNC) ? '0 : to_cnt_q + TO_W'(1);
    pl_we_d    = 1'b0;
    pl_addr_d  = pl_addr_q;
    pl_data_d  = pl_data_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    cmd_code_d = cmd_code_q;
    cmd_len_d  = cmd_len_q;
    // A byte arriving on the timeout cycle takes priority over the timeout
    if (byte_stb) begin
      case (pstate_q)
        P_SYNC: begin
          if (rx_byte_c == SYNC_BYTE) begin
            pstate_d = P_CMD;
            csum_d   = 8'd0;
          end
        end
        P_CMD: begin
          code_d   = rx_byte_c;
          csum_d   = csum_q ^ rx_byte_c;
          pstate_d = P_LEN;
        end
        P_LEN: begin
          csum_d = csum_q ^ rx_byte_c;
          len_d  = rx_byte_c;
          idx_d  = '0;
          if (rx_byte_c > 8'(MAX_LEN)) begin
            err_d      = 1'b1;
            err_code_d = ERR_LEN;
            pstate_d   = P_SYNC;
          end else if (rx_byte_c == 8'd0) begin
            pstate_d = P_CSUM;
          end else begin
            pstate_d = P_PAY;
          end
        end
        P_PAY: begin
          pl_we_d   = 1'b1;
          pl_addr_d = idx_q;
          pl_data_d = rx_byte_c;
          csum_d    = csum_q ^ rx_byte_c;
          idx_d     = idx_q + AW'(1);
          if (8'(idx_q) == len_q - 8'd1) pstate_d = P_CSUM;
        end
        P_CSUM: begin
          if (rx_byte_c == csum_q) begin
            valid_d    = 1'b1;
            cmd_code_d = code_q;
            cmd_len_d  = len_q;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_CSUM;
          end
          pstate_d = P_SYNC;
        end
        default: pstate_d = P_SYNC;
      endcase
    end else if (timeout_hit_c) begin
      err_d      = 1'b1;
      err_code_d = ERR_TO;
      pstate_d   = P_SYNC;
    end
  end

  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) begin
      pstate_q   <= P_SYNC;
      csum_q     <= '0;
      code_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      to_cnt_q   <= '0;
      pl_we_q    <= 1'b0;
      pl_addr_q  <= '0;
      pl_data_q  <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      cmd_code_q <= '0;
      cmd_len_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      pstate_q   <= pstate_d;
      csum_q     <= csum_d;
      code_q     <= code_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      to_cnt_q   <= to_cnt_d;
      pl_we_q    <= pl_we_d;
      pl_addr_q  <= pl_addr_d;
      pl_data_q  <= pl_data_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      cmd_code_q <= cmd_code_d;
      cmd_len_q  <= cmd_len_d;
      busy_q     <= (pstate_d != P_SYNC);
    end
  end

  assign bus.pl_we     = pl_we_q;
  assign bus.pl_addr   = pl_addr_q;
  assign bus.pl_data   = pl_data_q;
  assign bus.cmd_valid = valid_q;
  assign bus.cmd_code  = cmd_code_q;
  assign bus.cmd_len   = cmd_len_q;
  assign bus.cmd_err   = err_q;
  assign bus.err_code  = err_code_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Randomized and directed bench for uart_cmd_parser against a frame-level model.
module tb_uart_cmd_parser;

  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned TMO     = 50;

  typedef logic [7:0] bq_t[$];
  typedef struct { int kind; int a; int b; } ev_t;  // 0 write, 1 valid, 2 error

  logic rxclk = 1'b0;
  logic reset_n = 1'b0;
  always #5 rxclk = ~rxclk;

  uart_cmd_parser_if #(.AW(4)) bus ();

  uart_cmd_parser #(
    .SYNC_BYTE (8'hA5),
    .MAX_LEN   (MAX_LEN),
    .AW        (4),
    .TO_W      (20),
    .TIMEOUT   (20'(TMO))
  ) dut (
    .rxclk   (rxclk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int   n_checks = 0, n_errors = 0;
  int   cyc = 0, uld_double = 0;
  logic prev_uld = 1'b0, popped = 1'b0;
  bq_t  uart_q, stim;
  ev_t  exp_q[$], act_q[$];
  int   mdl_code = 0, mdl_len = 0, mdl_err = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One clock: sample outputs at the falling edge, then act as the UART
  task automatic tick();
    @(negedge rxclk);
    cyc++;
    if (bus.pl_we)     act_q.push_back('{0, int'(bus.pl_addr), int'(bus.pl_data)});
    if (bus.cmd_valid) act_q.push_back('{1, int'(bus.cmd_code), int'(bus.cmd_len)});
    if (bus.cmd_err)   act_q.push_back('{2, int'(bus.err_code), 0});
    if (bus.uld_rx_data && prev_uld) uld_double++;
    prev_uld = bus.uld_rx_data;
    popped   = 1'b0;
    if (bus.uld_rx_data && uart_q.size() > 0) begin
      bus.rx_data = uart_q.pop_front();
      popped      = 1'b1;
    end
    bus.rx_empty = (uart_q.size() == 0);
  endtask

  // Frame-level reference: walk the byte stream looking for whole frames
  function automatic void model(input bq_t s);
    int i = 0;
    int n = s.size();
    int code, len, x;
    while (i < n) begin
      if (s[i] != 8'hA5) begin i++; continue; end
      if (i + 2 >= n) break;
      code = int'(s[i+1]);
      len  = int'(s[i+2]);
      i += 3;
      if (len > int'(MAX_LEN)) begin
        exp_q.push_back('{2, 2, 0});
        mdl_err = 2;
        continue;
      end
      if (i + len >= n) break;
      x = code ^ len;
      for (int j = 0; j < len; j++) begin
        exp_q.push_back('{0, j, int'(s[i+j])});
        x ^= int'(s[i+j]);
      end
      i += len;
      if (int'(s[i]) == x) begin
        exp_q.push_back('{1, code, len});
        mdl_code = code;
        mdl_len  = len;
      end else begin
        exp_q.push_back('{2, 1, 0});
        mdl_err = 1;
      end
      i++;
    end
  endfunction

  // kind: 0 good, 1 bad checksum, 2 bad length, 3 zero length
  function automatic void add_frame(input int kind);
    logic [7:0] b, code, len, x;
    repeat ($urandom_range(0, 2)) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'hA5) b = 8'h00;
      stim.push_back(b);
    end
    code = 8'($urandom_range(0, 255));
    if (kind == 2) begin
      len = 8'($urandom_range(MAX_LEN + 1, 255));
      stim.push_back(8'hA5); stim.push_back(code); stim.push_back(len);
      return;
    end
    len = (kind == 3) ? 8'd0 : 8'($urandom_range(1, MAX_LEN));
    stim.push_back(8'hA5); stim.push_back(code); stim.push_back(len);
    x = code ^ len;
    for (int j = 0; j < int'(len); j++) begin
      b = 8'($urandom_range(0, 255));
      stim.push_back(b);
      x ^= b;
    end
    if (kind == 1) x ^= 8'($urandom_range(1, 255));
    stim.push_back(x);
  endfunction

  task automatic run_stream(input string tag);
    int budget;
    model(stim);
    foreach (stim[i]) uart_q.push_back(stim[i]);
    budget = 4 * stim.size() + 30;
    stim.delete();
    while (uart_q.size() > 0 && budget > 0) begin tick(); budget--; end
    if (budget == 0) check({tag, "_drain_timeout"}, 0, 1);
    repeat (8) tick();
    check({tag, "_n_events"}, act_q.size(), exp_q.size());
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      check({tag, "_ev_kind"}, act_q[i].kind, exp_q[i].kind);
      check({tag, "_ev_a"},    act_q[i].a,    exp_q[i].a);
      check({tag, "_ev_b"},    act_q[i].b,    exp_q[i].b);
    end
    act_q.delete();
    exp_q.delete();
    check({tag, "_cmd_code"}, int'(bus.cmd_code), mdl_code);
    check({tag, "_cmd_len"},  int'(bus.cmd_len),  mdl_len);
    check({tag, "_err_code"}, int'(bus.err_code), mdl_err);
    check({tag, "_busy"},     int'(bus.busy),     0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_uld"},      int'(bus.uld_rx_data), 0);
    check({tag, "_pl_we"},    int'(bus.pl_we),       0);
    check({tag, "_pl_addr"},  int'(bus.pl_addr),     0);
    check({tag, "_pl_data"},  int'(bus.pl_data),     0);
    check({tag, "_valid"},    int'(bus.cmd_valid),   0);
    check({tag, "_cmd_code"}, int'(bus.cmd_code),    0);
    check({tag, "_cmd_len"},  int'(bus.cmd_len),     0);
    check({tag, "_err"},      int'(bus.cmd_err),     0);
    check({tag, "_err_code"}, int'(bus.err_code),    0);
    check({tag, "_busy"},     int'(bus.busy),        0);
  endtask

  // Feed A5 10 and stop on the falling edge where the 10 is unloaded
  task automatic start_frame(input string tag);
    int budget = 20;
    uart_q.push_back(8'hA5);
    uart_q.push_back(8'h10);
    do begin tick(); budget--; end while (!(popped && uart_q.size() == 0) && budget > 0);
    if (budget == 0) check({tag, "_sync_timeout"}, 0, 1);
  endtask

  initial begin
    int budget;
    bus.rx_data  = 8'h00;
    bus.rx_empty = 1'b1;
    repeat (3) tick();
    check_all_zero("reset");
    reset_n = 1'b1;
    repeat (2) tick();

    stim = '{8'hA5, 8'h10, 8'h02, 8'h33, 8'h44, 8'h65};
    run_stream("two_byte");
    check("two_byte_code_direct", int'(bus.cmd_code), 8'h10);
    stim = '{8'hA5, 8'h20, 8'h00, 8'h20};
    run_stream("zero_len");
    stim = '{8'hA5, 8'h10, 8'h02, 8'h33, 8'h44, 8'h00,
             8'hA5, 8'h30, 8'h01, 8'hA5, 8'h94};
    run_stream("bad_csum");
    stim = '{8'h00, 8'hFF, 8'hA5, 8'h10, 8'h11};
    run_stream("bad_len");
    check("bad_len_err_direct", int'(bus.err_code), 2);

    // Mid-frame stall: error surfaces the cycle after the 50th idle cycle
    start_frame("tmo");
    repeat (TMO + 1) tick();
    check("tmo_early_err", int'(bus.cmd_err), 0);
    check("tmo_early_busy", int'(bus.busy), 1);
    check("tmo_no_events", act_q.size(), 0);
    tick();
    check("tmo_err", int'(bus.cmd_err), 1);
    check("tmo_err_code", int'(bus.err_code), 3);
    check("tmo_busy", int'(bus.busy), 0);
    tick();
    check("tmo_err_pulse", int'(bus.cmd_err), 0);
    mdl_err = 3;
    act_q.delete();

    // Byte fetched exactly on the timeout cycle keeps the frame alive
    start_frame("tmo_race");
    repeat (TMO - 2) tick();
    uart_q.push_back(8'h00);
    repeat (12) tick();
    check("tmo_race_no_err", act_q.size(), 0);
    check("tmo_race_busy", int'(bus.busy), 1);
    stim = '{8'h10};
    exp_q.push_back('{1, 8'h10, 0});
    foreach (stim[i]) uart_q.push_back(stim[i]);
    stim.delete();
    repeat (12) tick();
    mdl_code = 8'h10;
    mdl_len  = 0;
    check("tmo_race_n_events", act_q.size(), 1);
    if (act_q.size() > 0) begin
      check("tmo_race_kind", act_q[0].kind, 1);
      check("tmo_race_code", act_q[0].a, 8'h10);
      check("tmo_race_len",  act_q[0].b, 0);
    end
    act_q.delete();
    exp_q.delete();

    for (int r = 0; r < 20; r++) begin
      repeat ($urandom_range(1, 3)) add_frame($urandom_range(0, 9) < 5 ? 0 : int'($urandom_range(0, 3)));
      run_stream("rand");
    end

    // Reset mid-payload
    stim = '{8'hA5, 8'h42, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h00};
    foreach (stim[i]) uart_q.push_back(stim[i]);
    stim.delete();
    budget = 40;
    while (act_q.size() == 0 && budget > 0) begin tick(); budget--; end
    check("rst_saw_write", int'(act_q.size() > 0), 1);
    reset_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    uart_q.delete();
    bus.rx_empty = 1'b1;
    act_q.delete();
    mdl_code = 0; mdl_len = 0; mdl_err = 0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    stim = '{8'hA5, 8'h55, 8'h03, 8'hA5, 8'h00, 8'h7E, 8'h55 ^ 8'h03 ^ 8'hA5 ^ 8'h7E};
    run_stream("post_rst");

    check("uld_never_double", uld_double, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
